// File: rtl/mips8_pkg.sv
// Shared widths, opcode encodings and fetch FSM state type for the mips8 front end.
// Pure declarations; no timing or flow-control behaviour lives here.
package mips8_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LB    = 3'b010;
  localparam logic [2:0] OP_SB    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus: req/addr out, ready/rdata back in the same cycle.
// A transfer completes when req and ready are both high; addr must hold while req waits.
interface fetch_stage_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for an instruction fetched while decode is stalled.
// Load and pop take effect at the next edge; flush wins over load and pop.
module fetch_skid_buf #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_pop,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc2,
  output logic               o_full,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc2
);

  logic               r_full;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc2;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= '0;
      r_pc2   <= '0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc2   <= i_pc2;
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc2   = r_pc2;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register: one-cycle fetch-to-decode latency, redirect drains an in-flight request.
// Stall holds IF/ID, parks one returning instruction in the skid buffer and drops imem_req while it is full.
module fetch_stage #(
  parameter int              PC_W     = mips8_pkg::PC_W,
  parameter int              INSTR_W  = mips8_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc2,
  output logic               if_id_valid,
  output logic [2:0]         opcode,
  output logic               ctrl_kill
);

  import mips8_pkg::*;

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [PC_W-1:0]    r_tgt;
  logic [PC_W-1:0]    w_tgt_nxt;
  logic [PC_W-1:0]    w_pc_inc;
  logic               w_req;
  logic               w_fetch_xfer;

  logic               w_skid_full;
  logic               w_skid_load;
  logic               w_skid_pop;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [PC_W-1:0]    w_skid_pc2;

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc2;
  logic               r_valid;

  assign w_pc_inc = r_pc + PC_W'(2);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_tgt   <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  // In DRAIN r_pc keeps the abandoned address on the bus and r_tgt holds where to resume.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    w_req       = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_nxt = FETCH;
        if (redirect) begin
          w_pc_nxt = redirect_pc;
        end
      end
      FETCH: begin
        w_req = ~w_skid_full;
        if (redirect) begin
          if (w_req && !imem.imem_ready) begin
            w_state_nxt = DRAIN;
            w_tgt_nxt   = redirect_pc;
          end else begin
            w_pc_nxt = redirect_pc;
          end
        end else if (w_req && imem.imem_ready) begin
          w_pc_nxt = w_pc_inc;
        end
      end
      DRAIN: begin
        w_req = 1'b1;
        if (redirect) begin
          w_tgt_nxt = redirect_pc;
        end
        if (imem.imem_ready) begin
          w_state_nxt = FETCH;
          w_pc_nxt    = redirect ? redirect_pc : r_tgt;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

  assign w_fetch_xfer = (r_state == FETCH) && w_req && imem.imem_ready;
  assign w_skid_load  = w_fetch_xfer && stall && !redirect;
  assign w_skid_pop   = w_skid_full && !stall && !redirect;

  fetch_skid_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_pop   (w_skid_pop),
    .i_flush (redirect),
    .i_instr (imem.imem_rdata),
    .i_pc2   (w_pc_inc),
    .o_full  (w_skid_full),
    .o_instr (w_skid_instr),
    .o_pc2   (w_skid_pc2)
  );

  // A full skid buffer always drains ahead of memory; req is low then, so order is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc2   <= '0;
    end else if (redirect) begin
      r_valid <= 1'b0;
    end else if (!stall) begin
      if (w_skid_full) begin
        r_instr <= w_skid_instr;
        r_pc2   <= w_skid_pc2;
        r_valid <= 1'b1;
      end else if (w_fetch_xfer) begin
        r_instr <= imem.imem_rdata;
        r_pc2   <= w_pc_inc;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign if_id_instr = r_instr;
  assign if_id_pc2   = r_pc2;
  assign if_id_valid = r_valid;
  assign opcode      = r_instr[INSTR_W-1 -: 3];
  assign ctrl_kill   = ~r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based fetch model checked every cycle, plus literal pins.
module tb_fetch_stage;

  localparam int PW = 16;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          redirect;
  logic [PW-1:0] redirect_pc;
  logic [IW-1:0] if_id_instr;
  logic [PW-1:0] if_id_pc2;
  logic          if_id_valid;
  logic [2:0]    opcode;
  logic          ctrl_kill;

  always #5 clk = ~clk;

  fetch_stage_if #(.PC_W(PW), .INSTR_W(IW)) bus ();

  // Memory image: each word is the bitwise inverse of its address.
  assign bus.imem_rdata = ~bus.imem_addr;

  fetch_stage #(.PC_W(PW), .INSTR_W(IW), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .if_id_instr (if_id_instr),
    .if_id_pc2   (if_id_pc2),
    .if_id_valid (if_id_valid),
    .opcode      (opcode),
    .ctrl_kill   (ctrl_kill)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } ent_t;

  ent_t        q[$];
  bit          m_boot;
  bit          m_drain;
  bit          m_valid;
  logic [15:0] m_addr;
  logic [15:0] m_target;
  logic [15:0] m_instr;
  logic [15:0] m_pc2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_req();
    return !m_boot && (m_drain || q.size() == 0);
  endfunction

  // Fetched words queue up in program order; decode takes the oldest whenever not stalled.
  task automatic model_edge();
    bit   done;
    bit   pending;
    ent_t e;
    if (reset) begin
      m_boot = 1; m_drain = 0; m_addr = 16'h0000; m_target = 16'h0000;
      q.delete(); m_valid = 0; m_instr = 16'h0000; m_pc2 = 16'h0000;
      return;
    end
    done    = m_req() && bus.imem_ready;
    pending = m_req() && !bus.imem_ready;
    if (redirect) begin
      m_valid = 0;
      if (m_drain) begin
        m_target = redirect_pc;
        if (done) begin
          m_drain = 0;
          m_addr  = redirect_pc;
        end
      end else if (pending) begin
        m_drain  = 1;
        m_target = redirect_pc;
      end else begin
        m_addr = redirect_pc;
      end
      q.delete();
    end else begin
      if (m_drain) begin
        if (done) begin
          m_drain = 0;
          m_addr  = m_target;
        end
      end else if (done) begin
        e.instr = ~m_addr;
        e.pc2   = m_addr + 16'd2;
        q.push_back(e);
        m_addr  = m_addr + 16'd2;
      end
      if (!stall) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          m_valid = 1; m_instr = e.instr; m_pc2 = e.pc2;
        end else begin
          m_valid = 0;
        end
      end
    end
    m_boot = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", bus.imem_req, m_req());
      chk("imem_addr", bus.imem_addr, m_addr);
      chk("if_id_valid", if_id_valid, m_valid);
      chk("ctrl_kill", ctrl_kill, !m_valid);
      if (m_valid) begin
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc2", if_id_pc2, m_pc2);
        chk("opcode", opcode, m_instr[15:13]);
      end
    end
  end

  task automatic step(input bit rst, input bit s, input bit r, input logic [15:0] rp, input bit rdy);
    #1;
    reset = rst; stall = s; redirect = r; redirect_pc = rp; bus.imem_ready = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    reset = 1; stall = 0; redirect = 0; redirect_pc = '0; bus.imem_ready = 1'b1;

    step(1, 0, 0, 16'h0, 1);
    step(1, 0, 0, 16'h0, 1);
    chk_en = 1;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    chk("rst_valid", if_id_valid, 0);
    chk("rst_kill", ctrl_kill, 1);
    chk("rst_instr", if_id_instr, 16'h0000);
    chk("rst_pc2", if_id_pc2, 16'h0000);

    // startup sequence
    step(0, 0, 0, 16'h0, 1);
    chk("c2_addr", bus.imem_addr, 16'h0000);
    chk("c2_req", bus.imem_req, 1);
    chk("c2_valid", if_id_valid, 0);
    step(0, 0, 0, 16'h0, 1);
    chk("c3_addr", bus.imem_addr, 16'h0002);
    chk("c3_valid", if_id_valid, 1);
    chk("c3_pc2", if_id_pc2, 16'h0002);
    chk("c3_instr", if_id_instr, 16'hFFFF);
    step(0, 0, 0, 16'h0, 1);
    chk("c4_addr", bus.imem_addr, 16'h0004);
    chk("c4_pc2", if_id_pc2, 16'h0004);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 16'h0, 1);
    chk("run_addr", bus.imem_addr, 16'h0010);

    // memory wait states
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 16'h0, 0);
      chk("wait_addr", bus.imem_addr, 16'h0010);
      chk("wait_valid", if_id_valid, 0);
    end
    step(0, 0, 0, 16'h0, 1);
    chk("wait_instr", if_id_instr, 16'hFFEF);
    chk("wait_pc2", if_id_pc2, 16'h0012);

    // stall with skid buffer
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 16'h0, 1);
      chk("stall_req", bus.imem_req, 0);
      chk("stall_pc2", if_id_pc2, 16'h0012);
      chk("stall_instr", if_id_instr, 16'hFFEF);
    end
    step(0, 0, 0, 16'h0, 1);
    chk("unstall_pc2", if_id_pc2, 16'h0014);
    chk("unstall_instr", if_id_instr, 16'hFFED);
    chk("unstall_addr", bus.imem_addr, 16'h0014);
    step(0, 0, 0, 16'h0, 1);
    chk("unstall_next", if_id_pc2, 16'h0016);

    // redirect with a request outstanding
    step(0, 0, 1, 16'h0008, 1);
    chk("redir_addr", bus.imem_addr, 16'h0008);
    chk("redir_valid", if_id_valid, 0);
    step(0, 0, 1, 16'h0040, 0);
    chk("drain_addr", bus.imem_addr, 16'h0008);
    step(0, 0, 0, 16'h0, 0);
    chk("drain_hold", bus.imem_addr, 16'h0008);
    step(0, 0, 0, 16'h0, 1);
    chk("drain_done_addr", bus.imem_addr, 16'h0040);
    chk("drain_discard", if_id_valid, 0);
    step(0, 0, 0, 16'h0, 1);
    chk("drain_tgt_pc2", if_id_pc2, 16'h0042);
    chk("drain_tgt_instr", if_id_instr, 16'hFFBF);

    // second redirect during drain overrides the first
    step(0, 0, 1, 16'h0020, 0);
    step(0, 0, 1, 16'h0060, 0);
    step(0, 0, 0, 16'h0, 1);
    chk("latest_tgt", bus.imem_addr, 16'h0060);

    // address wrap
    step(0, 0, 1, 16'hFFFE, 1);
    step(0, 0, 0, 16'h0, 1);
    chk("wrap_addr", bus.imem_addr, 16'h0000);
    chk("wrap_pc2", if_id_pc2, 16'h0000);
    chk("wrap_opcode", opcode, 3'b000);

    // redirect and stall with a full buffer, odd target
    step(0, 1, 0, 16'h0, 1);
    chk("full_req", bus.imem_req, 0);
    step(0, 1, 1, 16'h0101, 1);
    chk("rs_valid", if_id_valid, 0);
    chk("rs_kill", ctrl_kill, 1);
    chk("rs_req", bus.imem_req, 1);
    chk("rs_addr", bus.imem_addr, 16'h0101);
    step(0, 0, 0, 16'h0, 1);
    chk("odd_pc2", if_id_pc2, 16'h0103);
    chk("odd_instr", if_id_instr, 16'hFEFE);

    // reset while draining
    step(0, 0, 1, 16'h0200, 0);
    step(1, 0, 0, 16'h0, 0);
    chk("rdrain_req", bus.imem_req, 0);
    chk("rdrain_addr", bus.imem_addr, 16'h0000);
    step(0, 0, 0, 16'h0, 1);
    chk("rdrain_fetch", bus.imem_addr, 16'h0000);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), 16'($urandom), ($urandom_range(0, 2) != 0));
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
